// File: rtl/fp32_div_seq_if.sv
// Request/result bundle for the sequential FP32 divider.
//
// Handshake: the master raises start with A/B stable; the divider accepts it
// only while idle (busy=0, done=0) and latches A/B on that clock edge. busy
// stays high while the operation is in flight. done is a one-cycle pulse and
// O/dz/nv are valid in that cycle; O/dz/nv then hold until the next done.
// start seen while busy or during the done cycle is dropped, not queued.
interface fp32_div_seq_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] O;
  logic        dz;
  logic        nv;

  modport master (output start, A, B, input busy, done, O, dz, nv);
  modport slave  (input start, A, B, output busy, done, O, dz, nv);
endinterface

// File: rtl/fp32_div_seq.sv
// Sequential IEEE-754 single-precision divider O = A / B.
// Restoring radix-2 mantissa division, one quotient bit per clock, fixed
// 29-cycle latency from accepted start to done, round to nearest even,
// denormal inputs and outputs flushed to signed zero.
module fp32_div_seq #(
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input  logic          clk,
  input  logic          rst,
  fp32_div_seq_if.slave bus,
  output logic [2:0]    dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_DIVIDE = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;

  logic [31:0]       a_q, a_d, b_q, b_d;
  logic              sign_q, sign_d;
  logic signed [9:0] e_q, e_d;
  logic [24:0]       r_q, r_d;
  logic [23:0]       mb_q, mb_d;
  logic [25:0]       q_q, q_d;
  logic              spec_q, spec_d;
  logic [31:0]       spec_o_q, spec_o_d;
  logic              spec_dz_q, spec_dz_d, spec_nv_q, spec_nv_d;
  logic [31:0]       o_q, o_d;
  logic              dz_q, dz_d, nv_q, nv_d;

  // Unpack / divide / round intermediates
  logic [7:0]        ea, eb;
  logic [23:0]       ma, mb;
  logic              lt;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
  logic              ge;
  logic [24:0]       diff;
  logic              up;
  logic [24:0]       sum;
  logic [22:0]       frac;
  logic signed [9:0] e_r;

  // FSM next state; DIVIDE counts 25 down to 0 for 26 quotient bits
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_UNPACK;
      S_UNPACK: begin
        state_d = S_DIVIDE;
        cnt_d   = 5'd25;
      end
      S_DIVIDE: begin
        if (cnt_q == 5'd0) state_d = S_ROUND;
        else               cnt_d   = cnt_q - 5'd1;
      end
      S_ROUND:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Operand classification, mantissa step and rounding arithmetic
  always_comb begin
    ea     = a_q[30:23];
    eb     = b_q[30:23];
    sgn    = a_q[31] ^ b_q[31];
    a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
    a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    ma     = {1'b1, a_q[22:0]};
    mb     = {1'b1, b_q[22:0]};
    lt     = ma < mb;

    // One restoring step: subtract when it fits, then shift the remainder
    ge   = r_q >= {1'b0, mb_q};
    diff = ge ? (r_q - {1'b0, mb_q}) : r_q;

    // Nearest-even on Q = {1.int, 23 frac, guard, round}, sticky from remainder
    up   = q_q[1] & (q_q[0] | (r_q != 25'd0) | q_q[2]);
    sum  = {1'b0, q_q[25:2]} + {24'd0, up};
    frac = sum[24] ? sum[23:1] : sum[22:0];
    e_r  = e_q + $signed({9'd0, sum[24]});
  end

  // Datapath next-state, everything holds unless its stage is active
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    sign_d    = sign_q;
    e_d       = e_q;
    r_d       = r_q;
    mb_d      = mb_q;
    q_d       = q_q;
    spec_d    = spec_q;
    spec_o_d  = spec_o_q;
    spec_dz_d = spec_dz_q;
    spec_nv_d = spec_nv_q;
    o_d       = o_q;
    dz_d      = dz_q;
    nv_d      = nv_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d = bus.A;
          b_d = bus.B;
        end
      end
      S_UNPACK: begin
        sign_d    = sgn;
        mb_d      = mb;
        r_d       = lt ? {ma, 1'b0} : {1'b0, ma};
        e_d       = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127
                    - $signed({9'd0, lt});
        q_d       = 26'd0;
        spec_d    = 1'b1;
        spec_dz_d = 1'b0;
        spec_nv_d = 1'b0;
        spec_o_d  = 32'd0;
        if (a_nan || b_nan) begin
          spec_o_d  = QNAN;
          spec_nv_d = 1'b1;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
          spec_o_d  = QNAN;
          spec_nv_d = 1'b1;
        end else if (a_inf) begin
          spec_o_d = {sgn, 8'hFF, 23'd0};
        end else if (b_inf || a_zero) begin
          spec_o_d = {sgn, 31'd0};
        end else if (b_zero) begin
          spec_o_d  = {sgn, 8'hFF, 23'd0};
          spec_dz_d = 1'b1;
        end else begin
          spec_d = 1'b0;
        end
      end
      S_DIVIDE: begin
        q_d = {q_q[24:0], ge};
        r_d = diff << 1;
      end
      S_ROUND: begin
        dz_d = spec_dz_q;
        nv_d = spec_nv_q;
        if (spec_q)                  o_d = spec_o_q;
        else if (e_r >= 10'sd255)    o_d = {sign_q, 8'hFF, 23'd0};
        else if (e_r <= 10'sd0)      o_d = {sign_q, 31'd0};
        else                         o_d = {sign_q, e_r[7:0], frac};
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      sign_q    <= 1'b0;
      e_q       <= 10'sd0;
      r_q       <= 25'd0;
      mb_q      <= 24'd0;
      q_q       <= 26'd0;
      spec_q    <= 1'b0;
      spec_o_q  <= 32'd0;
      spec_dz_q <= 1'b0;
      spec_nv_q <= 1'b0;
      o_q       <= 32'd0;
      dz_q      <= 1'b0;
      nv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_q    <= sign_d;
      e_q       <= e_d;
      r_q       <= r_d;
      mb_q      <= mb_d;
      q_q       <= q_d;
      spec_q    <= spec_d;
      spec_o_q  <= spec_o_d;
      spec_dz_q <= spec_dz_d;
      spec_nv_q <= spec_nv_d;
      o_q       <= o_d;
      dz_q      <= dz_d;
      nv_q      <= nv_d;
    end
  end

  assign bus.busy    = (state_q == S_UNPACK) || (state_q == S_DIVIDE) || (state_q == S_ROUND);
  assign bus.done    = (state_q == S_DONE);
  assign bus.O       = o_q;
  assign bus.dz      = dz_q;
  assign bus.nv      = nv_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fp32_div_seq.sv
// Testbench for fp32_div_seq: directed spec cases, handshake and reset
// scenarios, then random operands against a real-arithmetic reference.
module tb_fp32_div_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  fp32_div_seq_if bus();

  fp32_div_seq dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_assert = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];  // {dz, nv, O}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Exact widening of a normal single to double bit pattern
  function automatic logic [63:0] f2d_bits(input logic [31:0] x);
    return {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
  endfunction

  // Reference: specials from the class rules, otherwise a double-precision
  // quotient rounded to 24 significant bits (nearest even), then range flush.
  function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic        s, an, bn, ai, bi, az, bz;
    real         qa, qb;
    logic [63:0] d;
    int          ef;
    logic [23:0] m24;
    logic [28:0] rest;
    logic        rup;
    logic [24:0] m;
    s  = a[31] ^ b[31];
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az = (a[30:23] == 8'h00);
    bz = (b[30:23] == 8'h00);
    if (an || bn)                   return {2'b01, 32'h7FC00000};
    if ((az && bz) || (ai && bi))   return {2'b01, 32'h7FC00000};
    if (ai)                         return {2'b00, s, 8'hFF, 23'd0};
    if (bi || az)                   return {2'b00, s, 31'd0};
    if (bz)                         return {2'b10, s, 8'hFF, 23'd0};
    qa   = $bitstoreal(f2d_bits(a));
    qb   = $bitstoreal(f2d_bits(b));
    d    = $realtobits(qa / qb);
    ef   = int'(d[62:52]) - 1023 + 127;
    m24  = {1'b1, d[51:29]};
    rest = d[28:0];
    rup  = rest[28] & ((rest[27:0] != 0) | m24[0]);
    m    = {1'b0, m24} + {24'd0, rup};
    if (m[24]) begin
      m  = m >> 1;
      ef = ef + 1;
    end
    if (ef >= 255) return {2'b00, s, 8'hFF, 23'd0};
    if (ef <= 0)   return {2'b00, s, 31'd0};
    return {2'b00, s, ef[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 11))
      0:       return {s, 31'd0};
      1:       return {s, 8'hFF, 23'd0};
      2:       return {s, 8'hFF, 1'b1, 22'($urandom)};
      3:       return {s, 8'h00, 23'($urandom)};
      default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  // Driver: issue one operation, measure latency and busy width, score result
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [33:0] e;
    int lat, busy_n;
    bit seen;
    exp_q.push_back(ref_div(a, b));
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0; busy_n = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.done) seen = 1'b1;
      else if (bus.busy) busy_n++;
    end
    e = exp_q.pop_front();
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd29);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd28);
    check({tag, "_O"}, bus.O, e[31:0]);
    check({tag, "_dz"}, 32'(bus.dz), 32'(e[33]));
    check({tag, "_nv"}, 32'(bus.nv), 32'(e[32]));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int d1, d2, nd, nd_after;
    logic [31:0] o1, o2;
    logic [33:0] r;

    // Reset
    rst = 1'b1;
    bus.start = 1'b0;
    bus.A = 32'd0;
    bus.B = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_O", bus.O, 32'd0);
    check("rst_dz", 32'(bus.dz), 32'd0);
    check("rst_nv", 32'(bus.nv), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with literal expected values
    run_op(32'h40C00000, 32'h40000000, "six_div_two");
    check("six_div_two_lit", bus.O, 32'h40400000);
    run_op(32'h3F800000, 32'h40400000, "one_third");
    check("one_third_lit", bus.O, 32'h3EAAAAAB);
    run_op(32'h41100000, 32'hC0400000, "nine_div_m3");
    check("nine_div_m3_lit", bus.O, 32'hC0400000);
    run_op(32'h3F800000, 32'h00000000, "div_zero");
    check("div_zero_lit", {bus.O[31:0]}, 32'h7F800000);
    check("div_zero_dz_lit", 32'(bus.dz), 32'd1);
    run_op(32'h00000000, 32'h00000000, "zero_zero");
    check("zero_zero_lit", bus.O, 32'h7FC00000);
    check("zero_zero_nv_lit", 32'(bus.nv), 32'd1);
    run_op(32'hBF800000, 32'h7F800000, "x_div_inf");
    check("x_div_inf_lit", bus.O, 32'h80000000);
    run_op(32'h7FC00001, 32'h3F800000, "nan_in");
    check("nan_in_lit", bus.O, 32'h7FC00000);
    run_op(32'h7F800000, 32'h7F800000, "inf_inf");
    run_op(32'hFF800000, 32'h00000000, "inf_div_zero");
    run_op(32'h7F7FFFFF, 32'h3F000000, "overflow");
    check("overflow_lit", bus.O, 32'h7F800000);
    run_op(32'h00800000, 32'h40000000, "underflow");
    check("underflow_lit", bus.O, 32'h00000000);
    run_op(32'h00000001, 32'h3F800000, "denormal");
    check("denormal_lit", bus.O, 32'h00000000);

    // Handshake: start at N+5 and N+29 ignored, start at N+30 accepted
    d1 = -1; d2 = -1; nd = 0; o1 = '0; o2 = '0;
    @(negedge clk);
    bus.A = 32'h40C00000;
    bus.B = 32'h40000000;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 62; k++) begin
      @(negedge clk);
      if (bus.done) begin
        nd++;
        if (d1 < 0) begin
          d1 = k;
          o1 = bus.O;
        end else begin
          d2 = k;
          o2 = bus.O;
        end
      end
      bus.start = (k == 5) || (k == 29) || (k == 30);
      if (k == 5 || k == 29) begin
        bus.A = 32'h3F800000;
        bus.B = 32'h3F800000;
      end
      if (k == 30) begin
        bus.A = 32'h3F800000;
        bus.B = 32'h40400000;
      end
    end
    bus.start = 1'b0;
    check("hs_done_count", 32'(nd), 32'd2);
    check("hs_first_done_cycle", 32'(d1), 32'd29);
    check("hs_first_O", o1, 32'h40400000);
    check("hs_second_done_cycle", 32'(d2), 32'd59);
    check("hs_second_O", o2, 32'h3EAAAAAB);

    // Reset in flight: abandon 6/2 at N+10
    @(negedge clk);
    bus.A = 32'h40C00000;
    bus.B = 32'h40000000;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_O", bus.O, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd_after = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) nd_after++;
    end
    check("midrst_no_done", 32'(nd_after), 32'd0);
    run_op(32'h40C00000, 32'h40000000, "after_rst");
    check("after_rst_lit", bus.O, 32'h40400000);

    // Random operands against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      ra = rand_operand();
      rb = rand_operand();
      r  = ref_div(ra, rb);
      run_op(ra, rb, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
